// File: rtl/stream_rd_fetch.sv
// Host-memory read engine: chunks a buffer into PMTU-sized read requests,
// bounds outstanding requests and forwards the returned stream with one tlast.
module stream_rd_fetch #(
    parameter int PMTU_BYTES = 4096,
    parameter int DATA_BITS  = 512,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VADDR_BITS-1:0] vaddr,
    input  logic [LEN_BITS-1:0]   len,
    input  logic [PID_BITS-1:0]   pid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [VADDR_BITS-1:0] rd_req_vaddr,
    output logic [LEN_BITS-1:0]   rd_req_len,
    output logic                  rd_req_ctl,
    output logic [PID_BITS-1:0]   rd_req_pid,
    input  logic                  rd_done_valid,
    output logic                  rd_done_ready,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_BITS-1:0]  s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_BITS-1:0]  m_axis_tdata,
    output logic                  m_axis_tlast
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [LEN_BITS-1:0]   PMTU_L = LEN_BITS'(PMTU_BYTES);
    localparam logic [VADDR_BITS-1:0] PMTU_A = VADDR_BITS'(PMTU_BYTES);
    localparam logic [3:0]            MAX_O  = 4'(MAX_OUTST);
    localparam logic [LEN_BITS:0]     ONE_B  = (LEN_BITS+1)'(1);

    state_t                state, state_nx;
    logic [VADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]   rem_q;
    logic [PID_BITS-1:0]   pid_q;
    logic [LEN_BITS:0]     beats_tot, beats_cnt;
    logic [3:0]            outst;
    logic                  err_q;
    logic                  go, req_hs, beat_hs, more, dec, spurious;
    logic                  unused_tlast;

    assign unused_tlast  = s_axis_tlast;
    assign go            = (state == IDLE) && start;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = err_q;
    assign rd_done_ready = 1'b1;

    assign rd_req_valid = (state == ISSUE) && (outst < MAX_O);
    assign rd_req_vaddr = addr_q;
    assign rd_req_len   = (rem_q > PMTU_L) ? PMTU_L : rem_q;
    assign rd_req_ctl   = (rem_q <= PMTU_L);
    assign rd_req_pid   = pid_q;
    assign req_hs       = rd_req_valid && rd_req_ready;

    // A completion with nothing outstanding is an error and must not wrap.
    assign spurious = rd_done_valid && (outst == 4'd0);
    assign dec      = rd_done_valid && (outst != 4'd0);

    // Once every expected beat is through, extra input beats are refused.
    assign more          = (beats_cnt != beats_tot);
    assign m_axis_tvalid = s_axis_tvalid && busy && more;
    assign s_axis_tready = m_axis_tready && busy && more;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = (beats_cnt == beats_tot - ONE_B);
    assign beat_hs       = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (len != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (req_hs && rd_req_ctl) state_nx = DRAIN;
            end
            DRAIN: begin
                if (outst == 4'd0 && !more) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            pid_q     <= '0;
            beats_tot <= '0;
            beats_cnt <= '0;
            outst     <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                addr_q    <= vaddr;
                rem_q     <= len;
                pid_q     <= pid;
                beats_tot <= ({1'b0, len} + (LEN_BITS+1)'(63)) >> 6;
                beats_cnt <= '0;
                outst     <= '0;
                err_q     <= 1'b0;
            end else begin
                if (req_hs) begin
                    addr_q <= addr_q + PMTU_A;
                    rem_q  <= rem_q - rd_req_len;
                end
                outst <= outst + 4'(req_hs) - 4'(dec);
                if (spurious) err_q <= 1'b1;
                if (beat_hs) beats_cnt <= beats_cnt + ONE_B;
            end
        end
    end
endmodule

// File: tb/tb_stream_rd_fetch.sv
// Scoreboard bench for stream_rd_fetch: expected requests and beats are
// queued by the stimulus and popped by a negedge monitor.
module tb_stream_rd_fetch;
    localparam int DB = 512;
    localparam int VB = 48;
    localparam int LB = 28;
    localparam int PB = 6;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [VB-1:0] vaddr = '0;
    logic [LB-1:0] len = '0;
    logic [PB-1:0] pid = '0;
    logic          busy, done, err;
    logic          rd_req_valid;
    logic          rd_req_ready = 1'b1;
    logic [VB-1:0] rd_req_vaddr;
    logic [LB-1:0] rd_req_len;
    logic          rd_req_ctl;
    logic [PB-1:0] rd_req_pid;
    logic          rd_done_valid = 1'b0;
    logic          rd_done_ready;
    logic          s_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DB-1:0] s_tdata = '0;
    logic          m_axis_tvalid;
    logic          m_tready = 1'b1;
    logic [DB-1:0] m_axis_tdata;
    logic          m_axis_tlast;

    always #5 aclk = ~aclk;

    stream_rd_fetch #(.MAX_OUTST(2)) dut (
        .aclk(aclk), .reset(reset), .start(start),
        .vaddr(vaddr), .len(len), .pid(pid),
        .busy(busy), .done(done), .err(err),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_vaddr(rd_req_vaddr), .rd_req_len(rd_req_len),
        .rd_req_ctl(rd_req_ctl), .rd_req_pid(rd_req_pid),
        .rd_done_valid(rd_done_valid), .rd_done_ready(rd_done_ready),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(1'b0),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    typedef struct packed {
        logic [VB-1:0] a;
        logic [LB-1:0] l;
        logic          c;
        logic [PB-1:0] p;
    } req_t;

    typedef struct packed {
        logic [DB-1:0] d;
        logic          last;
    } beat_t;

    req_t  req_q[$];
    beat_t beat_q[$];
    req_t  mon_r;
    beat_t mon_b;
    int    vectors = 0;
    int    miscompares = 0;
    int    done_cnt = 0;
    int    req_cnt = 0;
    bit    chk_mirror = 1'b0;
    bit    rand_bp = 1'b0;

    task automatic chk(input string n, input logic [DB-1:0] act,
                       input logic [DB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] mk(input int tag, input int i);
        return {32{tag[7:0], i[7:0]}};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push_req(input logic [VB-1:0] a, input int l,
                            input logic c, input logic [PB-1:0] p);
        req_q.push_back('{a: a, l: LB'(l), c: c, p: p});
    endtask

    task automatic push_beats(input int n, input int tag);
        for (int i = 0; i < n; i++)
            beat_q.push_back('{d: mk(tag, i), last: (i == n - 1)});
    endtask

    task automatic go(input logic [VB-1:0] a, input int l,
                      input logic [PB-1:0] p);
        vaddr = a;
        len   = LB'(l);
        pid   = p;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic pulse_done();
        rd_done_valid = 1'b1;
        tick(1);
        rd_done_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int tag);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            s_tdata  = mk(tag, i);
            s_tvalid = 1'b1;
            @(negedge aclk);
            while (!s_axis_tready && t < 2000) begin
                @(negedge aclk);
                t++;
            end
            if (t >= 2000) begin
                chk("beat_timeout", t, 0);
                break;
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int k;
        k = 0;
        while (done_cnt < target && k < bound) begin
            tick(1);
            k++;
        end
        chk("done_seen", done_cnt, target);
        tick(3);
        chk("done_once", done_cnt, target);
        chk("idle_busy", busy, 0);
    endtask

    task automatic check_idle(input string n);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_done"}, done, 0);
        chk({n, "_err"}, err, 0);
        chk({n, "_reqv"}, rd_req_valid, 0);
        chk({n, "_mvalid"}, m_axis_tvalid, 0);
        chk({n, "_sready"}, s_axis_tready, 0);
        chk({n, "_tlast"}, m_axis_tlast, 0);
    endtask

    always @(negedge aclk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (chk_mirror && beat_q.size() != 0)
                chk("mirror", s_axis_tready, m_tready);
            if (rd_req_valid && rd_req_ready) begin
                req_cnt++;
                chk("req_pending", req_q.size() != 0, 1);
                if (req_q.size() != 0) begin
                    mon_r = req_q.pop_front();
                    chk("req", {rd_req_vaddr, rd_req_len, rd_req_ctl,
                                rd_req_pid}, mon_r);
                end
            end
            if (m_axis_tvalid && m_tready) begin
                chk("beat_pending", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    mon_b = beat_q.pop_front();
                    chk("beat_data", m_axis_tdata, mon_b.d);
                    chk("beat_last", m_axis_tlast, mon_b.last);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int dc0;
        tick(3);
        check_idle("rst");
        chk("rst_done_ready", rd_done_ready, 1);
        reset = 1'b0;
        tick(1);

        push_req(48'h1000, 4096, 1'b0, 6'd5);
        push_req(48'h2000, 4096, 1'b0, 6'd5);
        push_req(48'h3000, 1808, 1'b1, 6'd5);
        push_beats(157, 1);
        rc0 = req_cnt;
        go(48'h1000, 10000, 6'd5);
        chk("t1_valid", rd_req_valid, 1);
        fork
            send_beats(157, 1);
            begin
                tick(5); pulse_done();
                tick(5); pulse_done();
                tick(5); pulse_done();
            end
        join
        wait_done(1, 400);
        chk("t1_reqs", req_cnt - rc0, 3);
        chk("t1_err", err, 0);

        for (int k = 0; k < 5; k++)
            push_req(48'h10000 + 48'(k * 4096), 4096, 1'b0 | (k == 4), 6'd9);
        push_beats(320, 2);
        rc0 = req_cnt;
        go(48'h10000, 5 * 4096, 6'd9);
        tick(10);
        chk("lim_cnt", req_cnt - rc0, 2);
        chk("lim_valid", rd_req_valid, 0);
        for (int k = 0; k < 3; k++) begin
            pulse_done();
            tick(5);
            chk("lim_release", req_cnt - rc0, 3 + k);
        end
        pulse_done();
        pulse_done();
        send_beats(320, 2);
        wait_done(2, 400);
        chk("lim_err", err, 0);

        rd_req_ready = 1'b0;
        push_req(48'h40000, 4096, 1'b0, 6'd3);
        push_req(48'h41000, 4096, 1'b0, 6'd3);
        push_req(48'h42000, 4096, 1'b1, 6'd3);
        push_beats(192, 3);
        go(48'h40000, 3 * 4096, 6'd3);
        tick(2);
        rc0 = req_cnt;
        rd_req_ready = 1'b1;
        tick(1);
        rd_done_valid = 1'b1;
        tick(1);
        rd_done_valid = 1'b0;
        tick(4);
        chk("simul_cnt", req_cnt - rc0, 3);
        pulse_done();
        pulse_done();
        send_beats(192, 3);
        wait_done(3, 400);
        chk("simul_err", err, 0);

        pulse_done();
        tick(1);
        chk("spur_err", err, 1);

        rc0 = req_cnt;
        go(48'h5000, 0, 6'd1);
        chk("err_clear", err, 0);
        wait_done(4, 3);
        chk("zero_reqs", req_cnt - rc0, 0);

        push_req(48'h6000, 1, 1'b1, 6'd2);
        push_beats(1, 4);
        go(48'h6000, 1, 6'd2);
        fork
            send_beats(1, 4);
            begin tick(3); pulse_done(); end
        join
        wait_done(5, 400);

        push_req(48'h80000, 4096, 1'b0, 6'd7);
        push_req(48'h81000, 4096, 1'b1, 6'd7);
        push_beats(128, 5);
        rand_bp = 1'b1;
        chk_mirror = 1'b1;
        go(48'h80000, 8192, 6'd7);
        fork
            send_beats(128, 5);
            begin tick(4); pulse_done(); tick(1); pulse_done(); end
        join
        wait_done(6, 400);
        rand_bp = 1'b0;
        chk_mirror = 1'b0;
        tick(1);

        rd_req_ready = 1'b0;
        push_req(48'hA000, 4096, 1'b0, 6'd1);
        go(48'hA000, 3 * 4096, 6'd1);
        rc0 = req_cnt;
        rd_req_ready = 1'b1;
        tick(1);
        rd_req_ready = 1'b0;
        chk("mid_one_req", req_cnt - rc0, 1);
        dc0 = done_cnt;
        s_tvalid = 1'b1;
        reset = 1'b1;
        tick(1);
        check_idle("mid_rst");
        reset = 1'b0;
        s_tvalid = 1'b0;
        rd_req_ready = 1'b1;
        tick(2);
        chk("mid_no_done", done_cnt, dc0);
        push_req(48'hB000, 64, 1'b1, 6'd2);
        push_beats(1, 6);
        go(48'hB000, 64, 6'd2);
        fork
            send_beats(1, 6);
            begin tick(3); pulse_done(); end
        join
        wait_done(dc0 + 1, 400);
        chk("post_rst_err", err, 0);

        chk("req_q_empty", req_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
